// File: rtl/triangle_area_stream.sv
// Streaming signed triangle area: edge differences, cross products, then cull/abs/halve.
// Three registered stages with per-stage valid/advance so bubbles collapse and stalls never drop data.
module triangle_area_stream #(
   parameter int WIDTH = 17,
   parameter int FRAC  = 8,
   parameter int TAG_W = 8,
   parameter int CNT_W = 16
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic [2:0][1:0][WIDTH-1:0]  vertices_in,
   input  logic [1:0]                  cull_mode_in,
   input  logic [TAG_W-1:0]            tag_in,
   input  logic                        valid_in,
   output logic                        ready_out,
   output logic                        valid_out,
   input  logic                        ready_in,
   output logic                        negative_out,
   output logic [2*WIDTH-1:0]          area_out,
   output logic [TAG_W-1:0]            tag_out,
   output logic [CNT_W-1:0]            culled_count_out
);

   localparam int DW = WIDTH + 1;
   localparam int PW = 2 * WIDTH + 2;
   localparam int CW = 2 * WIDTH + 3;

   if (FRAC < 0 || FRAC > WIDTH) begin : g_frac_check
      $error("FRAC must lie within 0..WIDTH");
   end

   function automatic logic signed [DW-1:0] coord_diff(input logic [WIDTH-1:0] a,
                                                       input logic [WIDTH-1:0] b);
      return $signed({1'b0, a}) - $signed({1'b0, b});
   endfunction

   function automatic logic signed [PW-1:0] sext_p(input logic signed [DW-1:0] d);
      return {{(PW - DW){d[DW-1]}}, d};
   endfunction

   logic                  v1_r, v2_r;
   logic signed [DW-1:0]  dx1_r, dy1_r, dx2_r, dy2_r;
   logic [1:0]            mode1_r, mode2_r;
   logic [TAG_W-1:0]      tag1_r, tag2_r;
   logic signed [PW-1:0]  prod_a_r, prod_b_r;

   logic                  adv1_s, adv2_s, adv3_s;
   logic signed [PW-1:0]  prod_a_s, prod_b_s;
   logic signed [CW-1:0]  cross_s, abs_s;
   logic                  cross_neg_s, cross_zero_s, cull_s, load3_s;

   // Handshake: a stage moves when it is empty or its successor moves
   always_comb begin
      adv3_s    = !valid_out || ready_in;
      adv2_s    = !v2_r || adv3_s;
      adv1_s    = !v1_r || adv2_s;
      ready_out = adv1_s;
   end

   // Cross product evaluation and cull decision
   always_comb begin
      prod_a_s     = sext_p(dx1_r) * sext_p(dy2_r);
      prod_b_s     = sext_p(dx2_r) * sext_p(dy1_r);
      cross_s      = {prod_a_r[PW-1], prod_a_r} - {prod_b_r[PW-1], prod_b_r};
      cross_neg_s  = cross_s[CW-1];
      cross_zero_s = (cross_s == {CW{1'b0}});
      if (cross_neg_s) begin
         abs_s = -cross_s;
      end else begin
         abs_s = cross_s;
      end
      case (mode2_r)
         2'b00:   cull_s = 1'b0;
         2'b01:   cull_s = cross_neg_s;
         2'b10:   cull_s = !cross_neg_s && !cross_zero_s;
         2'b11:   cull_s = cross_zero_s;
         default: cull_s = 1'b0;
      endcase
      load3_s = v2_r && adv3_s && !cull_s;
   end

   // Stage 1: edge differences
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         v1_r    <= 1'b0;
         dx1_r   <= {DW{1'b0}};
         dy1_r   <= {DW{1'b0}};
         dx2_r   <= {DW{1'b0}};
         dy2_r   <= {DW{1'b0}};
         mode1_r <= 2'b00;
         tag1_r  <= {TAG_W{1'b0}};
      end else if (adv1_s) begin
         v1_r <= valid_in;
         if (valid_in) begin
            dx1_r   <= coord_diff(vertices_in[1][0], vertices_in[0][0]);
            dy1_r   <= coord_diff(vertices_in[1][1], vertices_in[0][1]);
            dx2_r   <= coord_diff(vertices_in[2][0], vertices_in[0][0]);
            dy2_r   <= coord_diff(vertices_in[2][1], vertices_in[0][1]);
            mode1_r <= cull_mode_in;
            tag1_r  <= tag_in;
         end
      end
   end

   // Stage 2: the two cross products
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         v2_r     <= 1'b0;
         prod_a_r <= {PW{1'b0}};
         prod_b_r <= {PW{1'b0}};
         mode2_r  <= 2'b00;
         tag2_r   <= {TAG_W{1'b0}};
      end else if (adv2_s) begin
         v2_r <= v1_r;
         if (v1_r) begin
            prod_a_r <= prod_a_s;
            prod_b_r <= prod_b_s;
            mode2_r  <= mode1_r;
            tag2_r   <= tag1_r;
         end
      end
   end

   // Stage 3: output register; culled triangles leave a bubble instead of loading
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         valid_out    <= 1'b0;
         negative_out <= 1'b0;
         area_out     <= {(2 * WIDTH){1'b0}};
         tag_out      <= {TAG_W{1'b0}};
      end else if (adv3_s) begin
         valid_out <= load3_s;
         if (load3_s) begin
            negative_out <= cross_neg_s;
            area_out     <= (2 * WIDTH)'(abs_s >> 1);
            tag_out      <= tag2_r;
         end
      end
   end

   // Saturating count of triangles dropped by culling
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         culled_count_out <= {CNT_W{1'b0}};
      end else if (v2_r && adv3_s && cull_s && (culled_count_out != {CNT_W{1'b1}})) begin
         culled_count_out <= culled_count_out + {{(CNT_W - 1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_triangle_area_stream.sv
// Directed self-checking bench for triangle_area_stream (WIDTH=17, 8 fractional bits).
module tb_triangle_area_stream;

   logic                  clk_in = 1'b0;
   logic                  rst_in;
   logic [2:0][1:0][16:0] vertices_in;
   logic [1:0]            cull_mode_in;
   logic [7:0]            tag_in;
   logic                  valid_in;
   logic                  ready_out;
   logic                  valid_out;
   logic                  ready_in;
   logic                  negative_out;
   logic [33:0]           area_out;
   logic [7:0]            tag_out;
   logic [15:0]           culled_count_out;

   int checks   = 0;
   int failures = 0;

   triangle_area_stream #(.WIDTH(17), .FRAC(8), .TAG_W(8), .CNT_W(16)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .vertices_in(vertices_in),
      .cull_mode_in(cull_mode_in), .tag_in(tag_in), .valid_in(valid_in),
      .ready_out(ready_out), .valid_out(valid_out), .ready_in(ready_in),
      .negative_out(negative_out), .area_out(area_out), .tag_out(tag_out),
      .culled_count_out(culled_count_out)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_tri(input int x0, input int y0, input int x1, input int y1,
                            input int x2, input int y2, input logic [1:0] mode,
                            input logic [7:0] tag);
      vertices_in[0][0] = 17'(x0);
      vertices_in[0][1] = 17'(y0);
      vertices_in[1][0] = 17'(x1);
      vertices_in[1][1] = 17'(y1);
      vertices_in[2][0] = 17'(x2);
      vertices_in[2][1] = 17'(y2);
      cull_mode_in = mode;
      tag_in       = tag;
      valid_in     = 1'b1;
   endtask

   // Offer one triangle for exactly one edge; returns at the following negedge.
   task automatic send_one(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input logic [1:0] mode,
                           input logic [7:0] tag);
      @(negedge clk_in);
      drive_tri(x0, y0, x1, y1, x2, y2, mode, tag);
      @(negedge clk_in);
      valid_in = 1'b0;
   endtask

   // Wait (bounded) for valid_out, sampling on negedges.
   task automatic watch_valid(input int max_cycles, output logic found);
      found = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         if (valid_out) begin
            found = 1'b1;
            break;
         end
         @(negedge clk_in);
      end
   endtask

   task automatic test_reset;
      rst_in = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
      cull_mode_in = 2'b00; tag_in = 8'h00; vertices_in = '0;
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;
      @(negedge clk_in);
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
      checks++; if (area_out !== 34'h0) begin failures++; $display("FAIL reset_area got=%0h exp=0", area_out); end
      checks++; if (negative_out !== 1'b0) begin failures++; $display("FAIL reset_neg got=%b exp=0", negative_out); end
      checks++; if (tag_out !== 8'h00) begin failures++; $display("FAIL reset_tag got=%0h exp=0", tag_out); end
      checks++; if (culled_count_out !== 16'h0) begin failures++; $display("FAIL reset_count got=%0d exp=0", culled_count_out); end
      checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_out); end
   endtask

   task automatic test_latency;
      @(negedge clk_in);
      drive_tri(24576, 1024, 0, 21248, 49152, 21248, 2'b00, 8'hA5);
      checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL lat_ready got=%b exp=1", ready_out); end
      @(negedge clk_in);
      valid_in = 1'b0;
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL lat_edge1 got=%b exp=0", valid_out); end
      @(negedge clk_in);
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL lat_edge2 got=%b exp=0", valid_out); end
      @(negedge clk_in);
      checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL lat_edge3 got=%b exp=1", valid_out); end
      checks++; if (area_out !== 34'h0_1DA0_0000) begin failures++; $display("FAIL lat_area got=%0h exp=1da00000", area_out); end
      checks++; if (negative_out !== 1'b1) begin failures++; $display("FAIL lat_neg got=%b exp=1", negative_out); end
      checks++; if (tag_out !== 8'hA5) begin failures++; $display("FAIL lat_tag got=%0h exp=a5", tag_out); end
      @(negedge clk_in);
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL lat_nodup got=%b exp=0", valid_out); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk_in);
      drive_tri(24576, 1024, 0, 21248, 49152, 21248, 2'b00, 8'h01);
      @(negedge clk_in);
      drive_tri(7680, 19424, 960, 3456, 960, 15392, 2'b00, 8'h02);
      @(negedge clk_in);
      valid_in = 1'b0;
      @(negedge clk_in);
      checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL b2b_v0 got=%b exp=1", valid_out); end
      checks++; if (area_out !== 34'h0_1DA0_0000) begin failures++; $display("FAIL b2b_area0 got=%0h exp=1da00000", area_out); end
      checks++; if (tag_out !== 8'h01) begin failures++; $display("FAIL b2b_tag0 got=%0h exp=01", tag_out); end
      @(negedge clk_in);
      checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL b2b_v1 got=%b exp=1", valid_out); end
      checks++; if (area_out !== 34'h0_0263_F400) begin failures++; $display("FAIL b2b_area1 got=%0h exp=263f400", area_out); end
      checks++; if (negative_out !== 1'b1) begin failures++; $display("FAIL b2b_neg1 got=%b exp=1", negative_out); end
      checks++; if (tag_out !== 8'h02) begin failures++; $display("FAIL b2b_tag1 got=%0h exp=02", tag_out); end
      @(negedge clk_in);
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", valid_out); end
   endtask

   // Triangle k of the stall test is (0,0),(k+1,0),(0,2): area k+1, positive, tag 0x10+k.
   task automatic test_stall;
      int   idx;
      int   out_idx;
      int   gaps;
      logic acc;
      idx = 0; out_idx = 0; gaps = 0;
      ready_in = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk_in);
         drive_tri(0, 0, idx + 1, 0, 0, 2, 2'b00, 8'(16 + idx));
         #1;
         acc = valid_in && ready_out;
         @(posedge clk_in);
         if (acc) idx++;
      end
      @(negedge clk_in);
      checks++; if (idx !== 3) begin failures++; $display("FAIL stall_accepted got=%0d exp=3", idx); end
      checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL stall_ready got=%b exp=0", ready_out); end
      checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL stall_valid got=%b exp=1", valid_out); end
      checks++; if (tag_out !== 8'h10) begin failures++; $display("FAIL stall_head_tag got=%0h exp=10", tag_out); end
      checks++; if (area_out !== 34'h1) begin failures++; $display("FAIL stall_head_area got=%0h exp=1", area_out); end
      ready_in = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (out_idx < 5) begin
            if (valid_out) begin
               checks++; if (tag_out !== 8'(16 + out_idx)) begin failures++; $display("FAIL drain_tag%0d got=%0h exp=%0h", out_idx, tag_out, 16 + out_idx); end
               checks++; if (area_out !== 34'(out_idx + 1)) begin failures++; $display("FAIL drain_area%0d got=%0h exp=%0h", out_idx, area_out, out_idx + 1); end
               out_idx++;
            end else if (out_idx > 0) begin
               gaps++;
            end
         end
         if (idx < 5) begin
            drive_tri(0, 0, idx + 1, 0, 0, 2, 2'b00, 8'(16 + idx));
         end else begin
            valid_in = 1'b0;
         end
         #1;
         acc = valid_in && ready_out;
         @(posedge clk_in);
         if (acc) idx++;
         @(negedge clk_in);
      end
      valid_in = 1'b0;
      checks++; if (out_idx !== 5) begin failures++; $display("FAIL drain_count got=%0d exp=5", out_idx); end
      checks++; if (gaps !== 0) begin failures++; $display("FAIL drain_gaps got=%0d exp=0", gaps); end
   endtask

   task automatic test_cull;
      logic found;
      send_one(24576, 1024, 0, 21248, 49152, 21248, 2'b01, 8'h31);
      watch_valid(6, found);
      checks++; if (found !== 1'b0) begin failures++; $display("FAIL cull01_valid got=%b exp=0", found); end
      checks++; if (culled_count_out !== 16'd1) begin failures++; $display("FAIL cull01_count got=%0d exp=1", culled_count_out); end
      send_one(24576, 1024, 0, 21248, 49152, 21248, 2'b10, 8'h32);
      watch_valid(6, found);
      checks++; if (found !== 1'b1) begin failures++; $display("FAIL cull10_valid got=%b exp=1", found); end
      checks++; if (area_out !== 34'h0_1DA0_0000) begin failures++; $display("FAIL cull10_area got=%0h exp=1da00000", area_out); end
      checks++; if (tag_out !== 8'h32) begin failures++; $display("FAIL cull10_tag got=%0h exp=32", tag_out); end
      checks++; if (culled_count_out !== 16'd1) begin failures++; $display("FAIL cull10_count got=%0d exp=1", culled_count_out); end
      @(negedge clk_in);
   endtask

   task automatic test_collinear;
      logic found;
      send_one(0, 0, 5, 5, 10, 10, 2'b00, 8'h41);
      watch_valid(6, found);
      checks++; if (found !== 1'b1) begin failures++; $display("FAIL col00_valid got=%b exp=1", found); end
      checks++; if (area_out !== 34'h0) begin failures++; $display("FAIL col00_area got=%0h exp=0", area_out); end
      checks++; if (negative_out !== 1'b0) begin failures++; $display("FAIL col00_neg got=%b exp=0", negative_out); end
      checks++; if (tag_out !== 8'h41) begin failures++; $display("FAIL col00_tag got=%0h exp=41", tag_out); end
      @(negedge clk_in);
      send_one(0, 0, 5, 5, 10, 10, 2'b11, 8'h42);
      watch_valid(6, found);
      checks++; if (found !== 1'b0) begin failures++; $display("FAIL col11_valid got=%b exp=0", found); end
      checks++; if (culled_count_out !== 16'd2) begin failures++; $display("FAIL col11_count got=%0d exp=2", culled_count_out); end
   endtask

   task automatic test_reset_in_flight;
      logic found;
      ready_in = 1'b0;
      @(negedge clk_in);
      drive_tri(0, 0, 1, 0, 0, 2, 2'b00, 8'h51);
      @(negedge clk_in);
      drive_tri(0, 0, 2, 0, 0, 2, 2'b00, 8'h52);
      @(negedge clk_in);
      drive_tri(0, 0, 3, 0, 0, 2, 2'b00, 8'h53);
      @(negedge clk_in);
      checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL rstf_pre_valid got=%b exp=1", valid_out); end
      drive_tri(0, 0, 4, 0, 0, 2, 2'b00, 8'h54);
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in   = 1'b0;
      valid_in = 1'b0;
      ready_in = 1'b1;
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL rstf_valid got=%b exp=0", valid_out); end
      checks++; if (culled_count_out !== 16'd0) begin failures++; $display("FAIL rstf_count got=%0d exp=0", culled_count_out); end
      checks++; if (tag_out !== 8'h00) begin failures++; $display("FAIL rstf_tag got=%0h exp=0", tag_out); end
      checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL rstf_ready got=%b exp=1", ready_out); end
      watch_valid(6, found);
      checks++; if (found !== 1'b0) begin failures++; $display("FAIL rstf_leak got=%b exp=0", found); end
   endtask

   initial begin
      test_reset;
      test_latency;
      test_back_to_back;
      test_stall;
      test_cull;
      test_collinear;
      test_reset_in_flight;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/triangle_area_stream.md
TRIANGLE_AREA_STREAM -- requirements
Module: triangle_area_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 17: unsigned vertex coordinate width.
REQ-002 SHALL have parameter FRAC, default 8: fractional bits per coordinate; documentation only, no effect on arithmetic.
REQ-003 SHALL have parameter TAG_W, default 8: sideband tag width.
REQ-004 SHALL have parameter CNT_W, default 16: culled-triangle counter width.
REQ-005 SHALL have ports (clock and reset first): clk_in input 1 system clock; rst_in input 1 synchronous active-high reset; one clock, reset synchronous active-high.
REQ-006 SHALL have vertices_in input [2:0][1:0][WIDTH-1:0]; vertices_in[i][0]=x, vertices_in[i][1]=y.
REQ-007 SHALL have cull_mode_in input 2, tag_in input TAG_W, valid_in input 1, ready_out output 1.
REQ-008 SHALL have valid_out output 1, ready_in input 1, negative_out output 1, area_out output 2*WIDTH, tag_out output TAG_W, culled_count_out output CNT_W.

Function
REQ-009 SHALL accept a triangle on a rising edge where valid_in && ready_out; cull_mode_in and tag_in are sampled with it.
REQ-010 SHALL use three registered stages: S1 edge differences (x1-x0, y1-y0, x2-x0, y2-y0, signed WIDTH+1); S2 two products (signed 2*WIDTH+2); S3 output register.
REQ-011 SHALL compute cross = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0) exactly at signed 2*WIDTH+3 width.
REQ-012 SHALL set negative_out = (cross < 0) and area_out = |cross| >> 1, truncated; |cross| <= (2^WIDTH-1)^2, so no saturation is needed.
REQ-013 SHALL have latency 3 edges when unstalled: the accept edge loads S1, the next loads S2, the next loads S3; valid_out is high after the third edge.
REQ-014 SHALL sustain one triangle per cycle when ready_in stays high.
REQ-015 SHALL advance each stage k when stage k is empty or stage k+1 advances; S3 advances when !valid_out || ready_in, so bubbles collapse.
REQ-016 SHALL drive ready_out = !valid_S1 || S1 advances; ready_out may depend combinationally on ready_in.
REQ-017 SHALL hold valid_out, negative_out, area_out and tag_out stable while valid_out && !ready_in; no loss or duplication.
REQ-018 SHALL apply cull_mode while moving S2 to S3: 00 none; 01 cull cross<0; 10 cull cross>0; 11 cull cross==0.
REQ-019 SHALL consume a culled triangle from S2 without loading S3, and increment culled_count_out by 1, saturating at all-ones.
REQ-020 SHALL pass zero-area triangles in modes 00, 01 and 10 with area_out=0 and negative_out=0.
REQ-021 SHALL carry tag_in unchanged to tag_out alongside its triangle.
REQ-022 SHALL hold outputs at their last value when valid_out=0; their content is don't-care for checking.

Reset
REQ-023 SHALL, on rst_in high at a rising edge, clear all stage valids and discard in-flight triangles; valid_out=0, negative_out=0, area_out=0, tag_out=0, culled_count_out=0.
REQ-024 SHALL drive ready_out=1 in the cycle after reset deasserts.
REQ-025 SHALL let reset take priority over an accept or advance on the same edge.

Verification
REQ-026 SHALL check: WIDTH=17, mode 00, vertices (x,y) (96,4),(0,83),(192,83) -> after 3 edges valid_out=1, area_out=0x1DA0_0000, negative_out=1.
REQ-027 SHALL check: (30,75.875),(3.75,13.5),(3.75,60.125) accepted back-to-back with REQ-026, tags 0x01/0x02 -> consecutive cycles give area_out=0x0263_F400, negative_out=1, tags in order.
REQ-028 SHALL check: ready_in held low, 5 triangles offered -> exactly 3 accepted, then ready_out=0 with the head output held stable; after ready_in rises, all 5 emerge in order, one per cycle.
REQ-029 SHALL check: REQ-026 triangle with mode 01 -> no valid_out, culled_count_out=1; the same triangle with mode 10 -> emitted.
REQ-030 SHALL check: collinear (0,0),(5,5),(10,10) -> mode 00 gives area_out=0, negative_out=0; mode 11 gives culled, count incremented.
REQ-031 SHALL check: rst_in pulsed with 3 triangles in flight -> no valid_out afterwards, culled_count_out=0, ready_out=1 the next cycle.
